// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: evaluates the branch condition, drives the redirect
// target, holds FLUSH for FLUSH_CYCLES unstalled cycles and counts taken branches.
module branch_resolve_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int OPCODE_WIDTH = 6,
   parameter int ADDR_WIDTH   = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    IVALID,
   input  logic                    STALL,
   input  logic [DATA_WIDTH-1:0]   IDATA,
   input  logic [OPCODE_WIDTH-1:0] OPCODE,
   input  logic [ADDR_WIDTH-1:0]   PC,
   input  logic [ADDR_WIDTH-1:0]   IMM,
   output logic                    BO,
   output logic [ADDR_WIDTH-1:0]   BTARGET,
   output logic                    FLUSH,
   output logic [COUNT_WIDTH-1:0]  BCOUNT
);

   localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(6'b010100);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQZ = OPCODE_WIDTH'(6'b010101);
   localparam logic [OPCODE_WIDTH-1:0] OP_BNEZ = OPCODE_WIDTH'(6'b010110);
   localparam logic [OPCODE_WIDTH-1:0] OP_BLTZ = OPCODE_WIDTH'(6'b010111);
   localparam logic [OPCODE_WIDTH-1:0] OP_BGEZ = OPCODE_WIDTH'(6'b011000);
   localparam logic [OPCODE_WIDTH-1:0] OP_JR   = OPCODE_WIDTH'(6'b011001);
   localparam logic [3:0]              FC_INIT = 4'(FLUSH_CYCLES - 1);

   typedef enum logic {IDLE, FLUSHING} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              fc_q, fc_d;
   logic                    bo_q, bo_d;
   logic                    flush_q, flush_d;
   logic [ADDR_WIDTH-1:0]   btarget_q, btarget_d;
   logic [COUNT_WIDTH-1:0]  bcount_q, bcount_d;
   logic                    cond, taken;
   logic [ADDR_WIDTH-1:0]   target;

   always_comb begin
      cond = 1'b0;
      case (OPCODE)
         OP_JMP:  cond = 1'b1;
         OP_BEQZ: cond = (IDATA == '0);
         OP_BNEZ: cond = (IDATA != '0);
         OP_BLTZ: cond = IDATA[DATA_WIDTH-1];
         OP_BGEZ: cond = ~IDATA[DATA_WIDTH-1];
         OP_JR:   cond = 1'b1;
         default: cond = 1'b0;
      endcase
      taken  = IVALID & cond;
      // PC-relative add wraps silently modulo 2^ADDR_WIDTH
      target = (OPCODE == OP_JR) ? IDATA[ADDR_WIDTH-1:0] : PC + IMM;
   end

   always_comb begin
      state_d   = state_q;
      fc_d      = fc_q;
      bo_d      = bo_q;
      flush_d   = flush_q;
      btarget_d = btarget_q;
      bcount_d  = bcount_q;
      if (!STALL) begin
         case (state_q)
            IDLE: begin
               bo_d    = taken;
               flush_d = taken;
               if (taken) begin
                  btarget_d = target;
                  fc_d      = FC_INIT;
                  if (bcount_q != '1) bcount_d = bcount_q + 1'b1;
                  state_d   = (FLUSH_CYCLES > 1) ? FLUSHING : IDLE;
               end
            end
            FLUSHING: begin
               // instruction in this slot is squashed regardless of IVALID
               bo_d = 1'b0;
               if (fc_q == 4'd0) begin
                  state_d = IDLE;
                  flush_d = 1'b0;
               end else begin
                  fc_d    = fc_q - 4'd1;
                  flush_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         fc_q      <= '0;
         bo_q      <= 1'b0;
         flush_q   <= 1'b0;
         btarget_q <= '0;
         bcount_q  <= '0;
      end else begin
         state_q   <= state_d;
         fc_q      <= fc_d;
         bo_q      <= bo_d;
         flush_q   <= flush_d;
         btarget_q <= btarget_d;
         bcount_q  <= bcount_d;
      end
   end

   assign BO      = bo_q;
   assign BTARGET = btarget_q;
   assign FLUSH   = flush_q;
   assign BCOUNT  = bcount_q;

endmodule
